recorder_core: RTL and testbench

- Consumes the 16-bit input-event word produced by the input controller: {code[15:12], mode[11:10], speed[9:6], interp[5], reserved[4:0]}.
- Runs the record/play/pause/stop state machine.
- Generates SRAM addresses and strobes at the audio sample rate, and applies fast/slow playback.
- Returns an active-low end-of-operation pulse to the input controller.

---
 rtl/recorder_core.sv | 187 ++++++++++++++++++
 tb/tb_recorder_core.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/recorder_core.sv
// recorder_core: record/play/pause/stop sequencer driving SRAM and DAC at the sample rate
// Ports: i_clk, i_rst_n (async active-low); i_input_event {code,mode,speed,interp,rsvd};
//        i_sample_tick frame strobe; i_adc_data record sample; i_sram_rdata (cycle after rd);
//        o_sram_addr/o_sram_wdata/o_sram_we/o_sram_rd SRAM port; o_dac_data playback sample;
//        o_stop_signal active-low end pulse; o_state FSM state; o_rec_len recorded length.
// Define RECORDER_SLOW_INTERP_EN to enable linear interpolation in SLOW playback.
module recorder_core #(
    parameter int ADDR_W   = 20,
    parameter int MAX_ADDR = 2**ADDR_W - 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_input_event,
    input  logic              i_sample_tick,
    input  logic [15:0]       i_adc_data,
    input  logic [15:0]       i_sram_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_wdata,
    output logic              o_sram_we,
    output logic              o_sram_rd,
    output logic [15:0]       o_dac_data,
    output logic              o_stop_signal,
    output logic [1:0]        o_state,
    output logic [ADDR_W:0]   o_rec_len
);
    localparam logic [3:0] REC_STOP = 4'd0, REC_PLAY = 4'd1, REC_PAUSE = 4'd2, REC_RECORD = 4'd3;
    localparam logic [1:0] REC_FAST = 2'd1, REC_SLOW = 2'd2;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(MAX_ADDR) + ONE;

    typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, PLAY = 2'd2, PAUSE = 2'd3} state_e;

    state_e state_q, state_d;
    logic [3:0] code, speed, sp, code_q, speed_q, slow_q, slow_d, k_q, k_d, sp_q, sp_d;
    logic [1:0] mode, mode_q;
    logic [ADDR_W:0] addr_q, addr_d, rec_len_q, rec_len_d, adv_addr;
    logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
    logic [15:0] dac_q, dac_d, prev_q, prev_d, nxt, ip_val;
    logic cmd, is_stop, is_play, is_pause, is_rec, tick, busy, play_tick, rd2, full, last;
    logic slow_wrap, ip_en, act, unused_rsvd;
    logic stop_q, stop_d, rd1_q, rd1_d, fin1_q, fin1_d, done_q, done_d, ip1_q, ip1_d;
    logic rd2_q, rd2_d, fin2_q, fin2_d, has_nxt_q, has_nxt_d;
    logic signed [16:0] diff;
    logic signed [21:0] quo;
    logic signed [17:0] sum;

    assign code  = i_input_event[15:12];
    assign mode  = i_input_event[11:10] == 2'd3 ? 2'd0 : i_input_event[11:10];
    assign speed = i_input_event[9:6];
    assign sp    = speed == 4'd0 ? 4'd1 : speed;
    // Only a change to a defined code counts as a command; it also swallows a coincident tick.
    assign cmd      = code != code_q && code[3:2] == 2'd0;
    assign is_stop  = cmd && code == REC_STOP;
    assign is_play  = cmd && code == REC_PLAY;
    assign is_pause = cmd && code == REC_PAUSE;
    assign is_rec   = cmd && code == REC_RECORD;
    assign tick     = i_sample_tick && !cmd;
    // Ticks are ignored while the final read drains or while the interpolation read is in flight.
    assign busy      = fin1_q || fin2_q || done_q || (rd1_q && ip1_q);
    assign play_tick = state_q == PLAY && tick && !busy;
    assign full      = addr_q[ADDR_W-1:0] == ADDR_W'(MAX_ADDR);
    assign slow_wrap = slow_q >= sp - 4'd1;
    assign adv_addr  = mode == REC_FAST ? addr_q + (ADDR_W+1)'(sp) :
                       mode == REC_SLOW && !slow_wrap ? addr_q : addr_q + ONE;
    assign last      = adv_addr >= rec_len_q;
`ifdef RECORDER_SLOW_INTERP_EN
    assign ip_en = mode == REC_SLOW && i_input_event[5];
`else
    assign ip_en = 1'b0;
`endif
    assign unused_rsvd = ^i_input_event[5:0];

    // Interpolated sample: prev + (next-prev)*k/speed, truncated toward zero and saturated.
    assign nxt    = has_nxt_q ? i_sram_rdata : prev_q;
    assign diff   = 17'(signed'(nxt)) - 17'(signed'(prev_q));
    assign quo    = 22'(diff) * 22'(signed'({1'b0, k_q})) / 22'(signed'({1'b0, sp_q}));
    assign sum    = 18'(signed'(prev_q)) + 18'(quo);
    assign ip_val = sum > 18'sd32767 ? 16'h7fff : sum < -18'sd32768 ? 16'h8000 : sum[15:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = is_rec ? RECORD : is_play && rec_len_q != '0 ? PLAY : IDLE;
            RECORD:  state_d = is_stop || (tick && full) ? IDLE : RECORD;
            PLAY:    state_d = is_stop || done_q ? IDLE : is_pause ? PAUSE : PLAY;
            default: state_d = is_stop || done_q ? IDLE : is_play ? PLAY : PAUSE;
        endcase
    end

    always_comb begin
        o_sram_we    = state_q == RECORD && tick;
        rd2          = state_q == PLAY && rd1_q && ip1_q && has_nxt_q;
        o_sram_rd    = play_tick || rd2;
        o_sram_addr  = rd2 ? nxt_addr_q : addr_q[ADDR_W-1:0];
        o_sram_wdata = o_sram_we ? i_adc_data : '0;
    end

    always_comb begin
        addr_d    = addr_q;
        rec_len_d = rec_len_q;
        slow_d    = slow_q;
        if (state_q == IDLE && (is_rec || is_play)) begin
            addr_d = '0;
            slow_d = '0;
        end
        if (state_q == IDLE && is_rec) rec_len_d = '0;
        if (state_q == RECORD && is_stop) rec_len_d = addr_q;
        if (o_sram_we) begin
            addr_d    = addr_q + ONE;
            rec_len_d = full ? FULL_LEN : rec_len_q;
        end
        if (play_tick) begin
            addr_d = adv_addr;
            slow_d = mode == REC_SLOW && !slow_wrap ? slow_q + 4'd1 : 4'd0;
        end
        if (mode != mode_q || speed != speed_q) slow_d = '0;
        act        = state_d == PLAY || state_d == PAUSE;
        rd1_d      = play_tick;
        fin1_d     = play_tick && last;
        ip1_d      = play_tick && ip_en;
        k_d        = play_tick ? slow_q : k_q;
        sp_d       = play_tick ? sp : sp_q;
        nxt_addr_d = play_tick ? addr_q[ADDR_W-1:0] + ADDR_W'(1) : nxt_addr_q;
        has_nxt_d  = play_tick ? addr_q + ONE < rec_len_q : has_nxt_q;
        prev_d     = rd1_q ? i_sram_rdata : prev_q;
        rd2_d      = rd1_q && ip1_q && act;
        fin2_d     = fin1_q && ip1_q && act;
        // The end pulse coincides with the final sample reaching the DAC.
        done_d     = act && ((rd1_q && fin1_q && !ip1_q) || (rd2_q && fin2_q));
        stop_d     = !(done_d || (o_sram_we && full) || (state_q == IDLE && is_play && rec_len_q == '0));
        dac_d      = !act ? '0 : rd2_q ? ip_val : rd1_q && !ip1_q ? i_sram_rdata : dac_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q     <= '0;
            mode_q     <= '0;
            speed_q    <= '0;
            addr_q     <= '0;
            rec_len_q  <= '0;
            slow_q     <= '0;
            dac_q      <= '0;
            stop_q     <= 1'b1;
            rd1_q      <= 1'b0;
            fin1_q     <= 1'b0;
            ip1_q      <= 1'b0;
            rd2_q      <= 1'b0;
            fin2_q     <= 1'b0;
            done_q     <= 1'b0;
            k_q        <= '0;
            sp_q       <= '0;
            nxt_addr_q <= '0;
            has_nxt_q  <= 1'b0;
            prev_q     <= '0;
        end else begin
            code_q     <= code;
            mode_q     <= mode;
            speed_q    <= speed;
            addr_q     <= addr_d;
            rec_len_q  <= rec_len_d;
            slow_q     <= slow_d;
            dac_q      <= dac_d;
            stop_q     <= stop_d;
            rd1_q      <= rd1_d;
            fin1_q     <= fin1_d;
            ip1_q      <= ip1_d;
            rd2_q      <= rd2_d;
            fin2_q     <= fin2_d;
            done_q     <= done_d;
            k_q        <= k_d;
            sp_q       <= sp_d;
            nxt_addr_q <= nxt_addr_d;
            has_nxt_q  <= has_nxt_d;
            prev_q     <= prev_d;
        end
    end

    assign o_dac_data    = dac_q;
    assign o_stop_signal = stop_q;
    assign o_state       = state_q;
    assign o_rec_len     = rec_len_q;
endmodule

// File: tb/tb_recorder_core.sv
// tb_recorder_core: directed bench for recorder_core with a small SRAM model
module tb_recorder_core;
    localparam int AW = 4;
    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic [15:0] ev = '0, adc = '0, rdata = '0;
    logic [AW-1:0] addr;
    logic [15:0] wdata, dac;
    logic we, rd, stop;
    logic [1:0] st;
    logic [AW:0] rlen;
    logic [15:0] mem [0:15];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    recorder_core #(.ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_input_event(ev), .i_sample_tick(tick),
        .i_adc_data(adc), .i_sram_rdata(rdata), .o_sram_addr(addr), .o_sram_wdata(wdata),
        .o_sram_we(we), .o_sram_rd(rd), .o_dac_data(dac), .o_stop_signal(stop),
        .o_state(st), .o_rec_len(rlen)
    );

    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (rd) rdata <= mem[addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] c, input logic [1:0] m, input logic [3:0] s);
        ev = {c, m, s, 6'b0};
        cyc();
    endtask

    task automatic rec_tick(input logic [15:0] d, input int a, input logic full_exp);
        tick = 1'b1;
        adc = d;
        #1;
        chk("rec_we", we, 1);
        chk("rec_addr", addr, a);
        chk("rec_wdata", wdata, d);
        chk("rec_rd", rd, 0);
        cyc();
        tick = 1'b0;
        adc = '0;
        chk("rec_stop", stop, !full_exp);
        chk("rec_state", st, full_exp ? 0 : 1);
        cyc();
    endtask

    task automatic play(input int a, input logic [15:0] d, input logic last);
        tick = 1'b1;
        #1;
        chk("play_rd", rd, 1);
        chk("play_addr", addr, a);
        chk("play_we", we, 0);
        cyc();
        tick = 1'b0;
        cyc();
        chk("play_dac", dac, d);
        chk("play_stop", stop, !last);
        cyc();
        if (last) begin
            chk("end_state", st, 0);
            chk("end_dac", dac, 0);
            chk("end_stop", stop, 1);
        end
    endtask

    initial begin
        cyc(2);
        chk("rst_state", st, 0);
        chk("rst_stop", stop, 1);
        chk("rst_len", rlen, 0);
        chk("rst_dac", dac, 0);
        chk("rst_we", we, 0);
        chk("rst_rd", rd, 0);
        chk("rst_addr", addr, 0);
        rst_n = 1'b1;
        cyc();
        cmd(4'd3, 2'd0, 4'd0);
        chk("rec_enter", st, 1);
        for (int i = 0; i < 5; i++) rec_tick(16'(10 + i), i, 1'b0);
        cmd(4'd0, 2'd0, 4'd0);
        chk("rec_stop_state", st, 0);
        chk("rec_len5", rlen, 5);
        cmd(4'd1, 2'd0, 4'd0);
        chk("normal_enter", st, 2);
        for (int i = 0; i < 5; i++) play(i, 16'(10 + i), i == 4);
        cmd(4'd0, 2'd0, 4'd0);
        cmd(4'd1, 2'd1, 4'd2);
        chk("fast_enter", st, 2);
        play(0, 16'd10, 1'b0);
        play(2, 16'd12, 1'b0);
        play(4, 16'd14, 1'b1);
        cmd(4'd0, 2'd0, 4'd0);
        cmd(4'd1, 2'd2, 4'd3);
        chk("slow_enter", st, 2);
        play(0, 16'd10, 1'b0);
        play(0, 16'd10, 1'b0);
        play(0, 16'd10, 1'b0);
        play(1, 16'd11, 1'b0);
        cmd(4'd2, 2'd2, 4'd3);
        chk("pause_enter", st, 3);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            #1;
            chk("pause_rd", rd, 0);
            chk("pause_we", we, 0);
            cyc();
            tick = 1'b0;
            cyc();
            chk("pause_dac", dac, 11);
        end
        cmd(4'd1, 2'd2, 4'd3);
        chk("resume_state", st, 2);
        play(1, 16'd11, 1'b0);
        play(1, 16'd11, 1'b0);
        play(2, 16'd12, 1'b0);
        cmd(4'd0, 2'd2, 4'd3);
        chk("slow_stop_state", st, 0);
        chk("slow_stop_dac", dac, 0);
        cmd(4'd3, 2'd0, 4'd0);
        chk("rec16_enter", st, 1);
        for (int i = 0; i < 16; i++) rec_tick(16'(100 + i), i, i == 15);
        chk("rec_len16", rlen, 16);
        cyc(3);
        chk("held_rec_state", st, 0);
        chk("held_rec_stop", stop, 1);
        cmd(4'd0, 2'd0, 4'd0);
        cmd(4'd1, 2'd0, 4'd0);
        chk("replay_enter", st, 2);
        play(0, 16'd100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", st, 0);
        chk("arst_dac", dac, 0);
        chk("arst_stop", stop, 1);
        chk("arst_len", rlen, 0);
        chk("arst_addr", addr, 0);
        chk("arst_rd", rd, 0);
        cyc();
        ev = '0;
        rst_n = 1'b1;
        cyc();
        cmd(4'd1, 2'd0, 4'd0);
        chk("empty_play_stop", stop, 0);
        chk("empty_play_state", st, 0);
        cyc();
        chk("empty_play_stop_end", stop, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
